// File: rtl/limn2600_bus_pkg.sv
// Shared definitions for the Limn2600 bus master: FSM state encoding,
// default widths and timeouts, and a small alignment helper.
package limn2600_bus_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_TIMEOUT    = 255;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Word accesses must have the two low address bits clear.
    function automatic logic is_aligned(input logic [1:0] addr_lsbs);
        return (addr_lsbs == 2'b00);
    endfunction

endpackage

// File: rtl/limn2600_bus_master_if.sv
// Bundles the CPU request/response handshake and the memory-side bus of
// the Limn2600 bus master into one interface with master/slave views.
interface limn2600_bus_master_if
    import limn2600_bus_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [31:0]           req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;
    logic                  cs;
    logic                  we;
    logic [31:0]           addr;
    logic [DATA_WIDTH-1:0] data_out;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rdy;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, data_in, rdy,
        output req_ready, resp_valid, resp_rdata, resp_err,
               cs, we, addr, data_out
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, data_in, rdy,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               cs, we, addr, data_out
    );

endinterface

// File: rtl/limn2600_bus_timer.sv
// Wait-state counter for the bus master: cleared outside a transaction,
// counts while enabled, and raises tc once the count reaches TIMEOUT.
module limn2600_bus_timer
    import limn2600_bus_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    assign tc = (count == CW'(TIMEOUT));

    // Count up while enabled and hold at the terminal value so it never wraps.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !tc) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/limn2600_bus_master.sv
// Limn2600 bus master: accepts one CPU request at a time, runs it on a
// simple cs/we/rdy memory bus, and returns a one-cycle response pulse.
// Misaligned requests and responders that never answer end in resp_err.
module limn2600_bus_master
    import limn2600_bus_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    limn2600_bus_master_if.master  bus
);

    logic [1:0] state;
    logic       timeout_hit;

    limn2600_bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != ST_WAIT),
        .enable (state == ST_WAIT),
        .tc     (timeout_hit)
    );

    assign bus.req_ready = (state == ST_IDLE);

    // Transaction FSM; every bus and response output is a register, and the
    // response fields fall back to zero whenever no pulse is being issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            bus.cs         <= 1'b0;
            bus.we         <= 1'b0;
            bus.addr       <= '0;
            bus.data_out   <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
        end else begin
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        if (is_aligned(bus.req_addr[1:0])) begin
                            bus.cs       <= 1'b1;
                            bus.we       <= bus.req_we;
                            bus.addr     <= bus.req_addr;
                            bus.data_out <= bus.req_wdata;
                            state        <= ST_WAIT;
                        end else begin
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            state          <= ST_DONE;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.rdy) begin
                        bus.cs         <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_rdata <= bus.we ? {DATA_WIDTH{1'b0}} : bus.data_in;
                        state          <= ST_DONE;
                    end else if (timeout_hit) begin
                        bus.cs         <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b1;
                        state          <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    bus.cs <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_limn2600_bus_master.sv
// Directed bench for the Limn2600 bus master against a small registered
// SRAM responder that can also be told to stall or to force rdy high.
module tb_limn2600_bus_master;

    localparam int TB_TIMEOUT = 8;
    localparam int NV = 7;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    limn2600_bus_master_if #(.DATA_WIDTH(32)) bus ();

    limn2600_bus_master #(
        .DATA_WIDTH (32),
        .TIMEOUT    (TB_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [0:255];
    logic        rdy_reg;
    logic [31:0] mem_data;
    logic        stuck;
    logic        rdy_force;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          exp_edge;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_cs;
        logic        exp_we;
    } vec_t;

    vec_t vecs [NV];

    // Zero-wait SRAM: rdy is cs delayed by one edge, unless told to stall.
    always @(posedge clk) begin
        if (rst) begin
            rdy_reg  <= 1'b0;
            mem_data <= '0;
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[4] <= 32'hDEADBEEF;
        end else begin
            rdy_reg <= stuck ? 1'b0 : bus.cs;
            if (bus.cs) begin
                if (bus.we) mem[bus.addr[9:2]] <= bus.data_out;
                mem_data <= mem[bus.addr[9:2]];
            end
        end
    end

    assign bus.rdy     = rdy_force ? 1'b1 : rdy_reg;
    assign bus.data_in = mem_data;

    // Hard stop in case something wedges the simulation.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [31:0] a,
                                 input logic [31:0] wd, output int resp_edge,
                                 output logic err, output logic [31:0] rdata,
                                 output int cs_cycles, output logic we_seen);
        resp_edge = -1;
        err       = 1'b0;
        rdata     = '0;
        cs_cycles = 0;
        we_seen   = 1'b0;
        checkOutput("ready_before_req", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        tick();
        bus.req_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.cs) begin
                cs_cycles++;
                if (bus.we) we_seen = 1'b1;
            end
            if (bus.resp_valid) begin
                resp_edge = k;
                err       = bus.resp_err;
                rdata     = bus.resp_rdata;
                break;
            end
            tick();
        end
        if (resp_edge < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL resp_wait_bound: no resp_valid within 40 cycles, required one");
        end
    endtask

    int          r_edge;
    int          r_cs;
    logic        r_err;
    logic        r_we;
    logic [31:0] r_rdata;
    int          last_accept;
    int          resp_count;

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        stuck         = 1'b0;
        rdy_force     = 1'b0;

        vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,          2, 1'b0, 32'hDEADBEEF, 2, 1'b0};
        vecs[1] = '{1'b1, 32'h00F8_0004, 32'h1234_5678,  2, 1'b0, 32'h0,        2, 1'b1};
        vecs[2] = '{1'b0, 32'h00F8_0004, 32'h0,          2, 1'b0, 32'h1234_5678, 2, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0002, 32'h0,          0, 1'b1, 32'h0,        0, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_0001, 32'hFFFF_FFFF,  0, 1'b1, 32'h0,        0, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_0020, 32'hA5A5_0F0F,  2, 1'b0, 32'h0,        2, 1'b1};
        vecs[6] = '{1'b0, 32'h0000_0020, 32'h0,          2, 1'b0, 32'hA5A5_0F0F, 2, 1'b0};

        repeat (3) tick();
        checkOutput("reset_cs",         64'(bus.cs),         64'd0);
        checkOutput("reset_we",         64'(bus.we),         64'd0);
        checkOutput("reset_addr",       64'(bus.addr),       64'd0);
        checkOutput("reset_data_out",   64'(bus.data_out),   64'd0);
        checkOutput("reset_resp_valid", 64'(bus.resp_valid), 64'd0);
        checkOutput("reset_resp_err",   64'(bus.resp_err),   64'd0);
        checkOutput("reset_resp_rdata", 64'(bus.resp_rdata), 64'd0);
        checkOutput("reset_req_ready",  64'(bus.req_ready),  64'd1);
        rst = 1'b0;
        tick();
        tick();

        $display("[TB] directed vector table");
        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata,
                          r_edge, r_err, r_rdata, r_cs, r_we);
            checkOutput($sformatf("v%0d_resp_edge", i), 64'(r_edge),  64'(vecs[i].exp_edge));
            checkOutput($sformatf("v%0d_resp_err", i),  64'(r_err),   64'(vecs[i].exp_err));
            checkOutput($sformatf("v%0d_rdata", i),     64'(r_rdata), 64'(vecs[i].exp_rdata));
            checkOutput($sformatf("v%0d_cs_cycles", i), 64'(r_cs),    64'(vecs[i].exp_cs));
            checkOutput($sformatf("v%0d_we_on_cs", i),  64'(r_we),    64'(vecs[i].exp_we));
            tick();
            checkOutput($sformatf("v%0d_pulse_len", i), 64'(bus.resp_valid), 64'd0);
            checkOutput($sformatf("v%0d_ready_after", i), 64'(bus.req_ready), 64'd1);
        end

        $display("[TB] timeout with stalled responder");
        stuck = 1'b1;
        applyStimulus(1'b0, 32'h0000_0030, 32'h0, r_edge, r_err, r_rdata, r_cs, r_we);
        checkOutput("to_resp_edge", 64'(r_edge),  64'(TB_TIMEOUT + 1));
        checkOutput("to_resp_err",  64'(r_err),   64'd1);
        checkOutput("to_rdata",     64'(r_rdata), 64'd0);
        checkOutput("to_cs_cycles", 64'(r_cs),    64'(TB_TIMEOUT + 1));
        checkOutput("to_cs_dropped", 64'(bus.cs), 64'd0);
        rdy_force = 1'b1;
        tick();
        checkOutput("to_stale_rdy_resp", 64'(bus.resp_valid), 64'd0);
        checkOutput("to_stale_rdy_cs",   64'(bus.cs),         64'd0);
        checkOutput("to_ready_after",    64'(bus.req_ready),  64'd1);
        rdy_force = 1'b0;
        stuck     = 1'b0;
        tick();

        $display("[TB] back-to-back requests");
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0000_0010;
        bus.req_wdata = '0;
        bus.req_valid = 1'b1;
        last_accept   = -1;
        resp_count    = 0;
        for (int e = 0; e < 16; e++) begin
            if (bus.resp_valid) begin
                resp_count++;
                checkOutput("b2b_resp_latency", 64'(e - last_accept), 64'd2);
                checkOutput("b2b_rdata", 64'(bus.resp_rdata), 64'hDEADBEEF);
                checkOutput("b2b_err",   64'(bus.resp_err),   64'd0);
            end
            checkOutput("b2b_ready_only_idle", 64'(bus.req_ready & bus.cs), 64'd0);
            if (bus.req_ready) begin
                if (last_accept >= 0)
                    checkOutput("b2b_accept_gap", 64'(e + 1 - last_accept), 64'd4);
                last_accept = e + 1;
            end
            if (e == 14) bus.req_valid = 1'b0;
            tick();
        end
        checkOutput("b2b_resp_count", 64'(resp_count), 64'd4);
        checkOutput("b2b_idle_after", 64'(bus.req_ready), 64'd1);

        $display("[TB] reset during WAIT");
        stuck         = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0000_0040;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        checkOutput("rw_cs_in_wait", 64'(bus.cs), 64'd1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        checkOutput("rw_cs_at_reset",    64'(bus.cs),         64'd0);
        checkOutput("rw_no_resp",        64'(bus.resp_valid), 64'd0);
        checkOutput("rw_ready_in_reset", 64'(bus.req_ready),  64'd1);
        tick();
        rst       = 1'b0;
        stuck     = 1'b0;
        rdy_force = 1'b1;
        tick();
        checkOutput("rw_rdy_after_release_resp", 64'(bus.resp_valid), 64'd0);
        checkOutput("rw_rdy_after_release_cs",   64'(bus.cs),         64'd0);
        rdy_force = 1'b0;
        tick();
        checkOutput("rw_no_resp_later", 64'(bus.resp_valid), 64'd0);
        checkOutput("rw_ready_after",   64'(bus.req_ready),  64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/limn2600_bus_master.md
LIMN2600_BUS_MASTER -- requirements
Module: limn2600_bus_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width of bus data.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum cycles in WAIT before error.
REQ-003 SHALL have port clk  input  1  the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  CPU request present.
REQ-006 SHALL have port req_ready  output  1  master can accept a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  DATA_WIDTH  write data.
REQ-010 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata  output  DATA_WIDTH  read data; 0 for writes and errors.
REQ-012 SHALL have port resp_err  output  1  qualifies resp_valid: misaligned or timeout.
REQ-013 SHALL have port cs  output  1  memory chip select.
REQ-014 SHALL have port we  output  1  memory write enable.
REQ-015 SHALL have port addr  output  32  memory address.
REQ-016 SHALL have port data_out  output  DATA_WIDTH  write data to memory.
REQ-017 SHALL have port data_in  input  DATA_WIDTH  read data from memory, valid when rdy=1.
REQ-018 SHALL have port rdy  input  1  memory ready; registered, may remain high one cycle after cs falls.

Function
REQ-019 SHALL implement states IDLE, WAIT, DONE; req_ready=1 only in IDLE.
REQ-020 SHALL accept a request on a rising edge where state=IDLE and req_valid=1, latching req_we, req_addr and req_wdata.
REQ-021 SHALL, for an aligned request (req_addr[1:0]=0), drive cs=1, we=req_we, addr and data_out from the registered copies, and enter WAIT.
REQ-022 SHALL, for a misaligned request, keep cs=0, enter DONE, and assert resp_valid=1, resp_err=1, resp_rdata=0 for exactly one cycle.
REQ-023 SHALL, in WAIT, count cycles from 0 and hold cs, we, addr and data_out stable.
REQ-024 SHALL, in WAIT with rdy=1, capture data_in into resp_rdata (reads) or 0 (writes), drop cs, assert resp_valid=1 with resp_err=0 for one cycle, and enter DONE.
REQ-025 SHALL, in WAIT when the count equals TIMEOUT with rdy=0, drop cs, assert resp_valid=1, resp_err=1, resp_rdata=0, and enter DONE.
REQ-026 SHALL treat rdy arriving on the same cycle as the timeout as success.
REQ-027 SHALL spend exactly one cycle in DONE with cs=0, ignore rdy there (stale), and return to IDLE.
REQ-028 SHALL, against a zero-wait responder, give an aligned-request latency of 3 cycles: accept at edge N, cs high during cycle N+1, rdy seen at edge N+2, resp_valid high during cycle N+3, req_ready=1 again in cycle N+4.
REQ-029 SHALL ignore req_valid outside IDLE; there is no response backpressure.
REQ-030 SHALL keep all memory-side outputs and resp_* as registered outputs.

Reset
REQ-031 SHALL, while rst=1, set state=IDLE, cs=0, we=0, addr=0, data_out=0, resp_valid=0, resp_err=0, resp_rdata=0, count=0.
REQ-032 SHALL, on reset during WAIT or DONE, abandon the transaction with no resp_valid, and drop cs at the reset edge.
REQ-033 SHALL ignore rdy in the first cycle after reset release.

Structure
REQ-034 SHALL place the state encoding, the DATA_WIDTH default and the TIMEOUT default in shared package limn2600_bus_pkg.
REQ-035 SHALL use one sub-module, limn2600_bus_timer, a clearable/enabled counter with a terminal-count flag at TIMEOUT.

Verification
REQ-036 SHALL cover: read of 0x00000010 from a zero-wait SRAM model holding 0xDEADBEEF -> resp_valid in cycle N+3, resp_rdata=0xDEADBEEF, resp_err=0, cs high for exactly 2 cycles.
REQ-037 SHALL cover: write 0x12345678 to 0x00F80004, then read back the same address -> we=1 with cs on the write, read returns 0x12345678, and the second request is accepted no earlier than cycle N+4.
REQ-038 SHALL cover: read of 0x00000002 -> cs never asserted, resp_valid=1 with resp_err=1 at cycle N+1.
REQ-039 SHALL cover: responder holds rdy=0 with TIMEOUT=8 -> cs drops and resp_err=1 after 8 WAIT cycles; rdy then asserted in DONE is ignored.
REQ-040 SHALL cover: rst=1 asserted during WAIT -> cs=0 on the next edge, no resp_valid, req_ready=1 after release.
REQ-041 SHALL cover: back-to-back requests with req_valid held high -> each accepted only in IDLE, and the stale rdy in DONE never completes the following request.
